// File: rtl/ifu_pkg.sv
// ifu_pkg: shared fetch-unit types and constants.
package ifu_pkg;
    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} fetch_state_e;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0200_0000;
    localparam int INST_WIDTH = 32;
    localparam logic [INST_WIDTH-1:0] NOP_CODE = 32'h0000_0013;
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction memory req/gnt/rvalid bus.
interface instruction_fetch_if;
    import ifu_pkg::*;
    logic                  req;
    logic [31:0]           addr;
    logic                  gnt;
    logic                  rvalid;
    logic [INST_WIDTH-1:0] rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry {pc, inst} buffer with synchronous push/pop/flush.
module fetch_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [31:0]                  pc_i,
    input  logic [INST_WIDTH-1:0]        inst_i,
    output logic                         valid_o,
    output logic [31:0]                  pc_o,
    output logic [INST_WIDTH-1:0]        inst_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    logic [31+INST_WIDTH:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic do_pop;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (int'(p) == DEPTH-1) ? '0 : p + PW'(1);
    endfunction
    assign do_pop  = pop_i && count_q != '0;
    assign valid_o = count_q != '0;
    assign count_o = count_q;
    assign {pc_o, inst_o} = valid_o ? mem_q[rd_q] : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= push_i ? nxt(wr_q) : wr_q;
            rd_q    <= do_pop ? nxt(rd_q) : rd_q;
            count_q <= count_q + CW'(push_i) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= {pc_i, inst_i};
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, credit-limited memory requests and redirect flush
// feeding a small FIFO toward instruction_decode.
module instruction_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instruction_fetch_if.master    imem,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [INST_WIDTH-1:0]  instruction_code,
    output logic [31:0]            inst_pc
);
    localparam int CW = $clog2(DEPTH+1);
    fetch_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d, rsp_pc;
    logic [CW-1:0] out_q, out_d, disc_q, disc_d, count;
    logic grant, rsp, push, flush;
    assign imem.req  = state_q == FETCH && (int'(out_q) + int'(count)) < DEPTH;
    assign imem.addr = pc_q;
    assign grant = imem.req && imem.gnt;
    assign rsp   = imem.rvalid && out_q != '0;
    assign flush = redirect_valid && state_q != BOOT;
    assign push  = rsp && state_q == FETCH && disc_q == '0 && !redirect_valid;
    assign out_d = out_q + CW'(grant) - CW'(rsp);
    // In FETCH all outstanding requests are contiguous and end just below pc_q.
    assign rsp_pc = pc_q - (32'(out_q) << 2);
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        disc_d  = disc_q;
        if (state_q == BOOT) begin
            state_d = FETCH;
            pc_d    = redirect_valid ? word_align(redirect_pc) : pc_q;
        end else if (redirect_valid) begin
            pc_d    = word_align(redirect_pc);
            disc_d  = out_d;
            state_d = out_d == '0 ? FETCH : DRAIN;
        end else if (state_q == FETCH) begin
            pc_d = grant ? pc_q + 32'd4 : pc_q;
        end else begin
            disc_d  = disc_q - CW'(rsp && disc_q != '0);
            state_d = disc_d == '0 ? FETCH : DRAIN;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            disc_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
        end
    end
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (inst_valid && inst_ready),
        .flush_i (flush),
        .pc_i    (rsp_pc),
        .inst_i  (imem.rdata),
        .valid_o (inst_valid),
        .pc_o    (inst_pc),
        .inst_o  (instruction_code),
        .count_o (count)
    );
    a_rvalid_credit: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem.rvalid && out_q == '0));
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: vector table plus directed corner sequences, with a
// scoreboard of granted words checked against every decoder pop.
module tb_instruction_fetch;
    import ifu_pkg::*;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    instruction_fetch_if imem();
    logic redirect_valid = 0, inst_ready = 0, gnt_en = 0, hold_rsp = 0;
    logic [31:0] redirect_pc = 0, instruction_code, inst_pc;
    logic inst_valid;
    int n_cmp = 0, n_fail = 0;
    instruction_fetch #(.RESET_PC(32'h0200_0000), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .imem(imem),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .instruction_code(instruction_code), .inst_pc(inst_pc)
    );
    assign imem.gnt = gnt_en & imem.req;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0200_0000: return 32'h0000_0797;
            32'h0200_0004: return 32'h02c7_8793;
            32'h0200_0008: return 32'h1a50_00ef;
            default:       return a ^ 32'hc0de_5a5a;
        endcase
    endfunction
    logic [31:0] pend[$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            imem.rvalid <= 1'b0;
            imem.rdata  <= '0;
        end else begin
            if (imem.req && imem.gnt) pend.push_back(imem.addr);
            imem.rvalid <= 1'b0;
            if (!hold_rsp && pend.size() > 0) begin
                imem.rvalid <= 1'b1;
                imem.rdata  <= mem_word(pend.pop_front());
            end
        end
    end
    typedef struct {logic [31:0] pc; logic [31:0] code;} exp_t;
    exp_t sb[$];
    logic [31:0] exp_pc = 32'h0200_0000;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            exp_pc = 32'h0200_0000;
        end else begin
            if (!inst_valid) begin
                check("idle_code", instruction_code, 32'h0);
                check("idle_pc", inst_pc, 32'h0);
            end else if (inst_ready && !redirect_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL pop_unexpected at %0t: got pc %h with no word expected", $time, inst_pc);
                end else begin
                    e = sb.pop_front();
                    check("pop_pc", inst_pc, e.pc);
                    check("pop_code", instruction_code, e.code);
                end
            end
            if (imem.req && imem.gnt) begin
                check("grant_addr", imem.addr, exp_pc);
                sb.push_back('{exp_pc, mem_word(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) begin
                sb.delete();
                exp_pc = redirect_pc & ~32'h3;
            end
        end
    end
    typedef struct {
        logic gnt; logic ready;
        logic req; logic [31:0] addr; logic valid; logic [31:0] pc; logic [31:0] code;
    } vec_t;
    vec_t tbl[10];
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic expect_out(input string name, input logic req, input logic [31:0] addr, input logic valid);
        @(negedge clk);
        check({name, "_req"}, imem.req, req);
        if (req) check({name, "_addr"}, imem.addr, addr);
        check({name, "_valid"}, inst_valid, valid);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        int k;
        tbl[0] = '{1, 0, 0, 32'h0200_0000, 0, 32'h0, 32'h0};
        tbl[1] = '{1, 0, 1, 32'h0200_0000, 0, 32'h0, 32'h0};
        tbl[2] = '{1, 0, 1, 32'h0200_0004, 0, 32'h0, 32'h0};
        tbl[3] = '{1, 0, 0, 32'h0, 1, 32'h0200_0000, 32'h0000_0797};
        tbl[4] = '{1, 0, 0, 32'h0, 1, 32'h0200_0000, 32'h0000_0797};
        tbl[5] = '{1, 0, 0, 32'h0, 1, 32'h0200_0000, 32'h0000_0797};
        tbl[6] = '{1, 1, 0, 32'h0, 1, 32'h0200_0000, 32'h0000_0797};
        tbl[7] = '{1, 1, 1, 32'h0200_0008, 1, 32'h0200_0004, 32'h02c7_8793};
        tbl[8] = '{1, 1, 1, 32'h0200_000c, 0, 32'h0, 32'h0};
        tbl[9] = '{1, 1, 0, 32'h0, 1, 32'h0200_0008, 32'h1a50_00ef};
        repeat (2) @(negedge clk);
        check("rst_req", imem.req, 0);
        check("rst_addr", imem.addr, 32'h0200_0000);
        check("rst_valid", inst_valid, 0);
        check("rst_code", instruction_code, 0);
        check("rst_pc", inst_pc, 0);
        tick();
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            gnt_en = tbl[i].gnt;
            inst_ready = tbl[i].ready;
            @(negedge clk);
            check($sformatf("vec%0d_req", i), imem.req, tbl[i].req);
            if (tbl[i].req) check($sformatf("vec%0d_addr", i), imem.addr, tbl[i].addr);
            check($sformatf("vec%0d_valid", i), inst_valid, tbl[i].valid);
            check($sformatf("vec%0d_pc", i), inst_pc, tbl[i].pc);
            check($sformatf("vec%0d_code", i), instruction_code, tbl[i].code);
            tick();
        end
        // Fill the FIFO, then pulse reset mid-stream.
        inst_ready = 0;
        repeat (3) tick();
        expect_out("full_hold", 0, 32'h0, 1);
        tick();
        rst_n = 0;
        #1;
        check("async_rst_valid", inst_valid, 0);
        check("async_rst_req", imem.req, 0);
        check("async_rst_code", instruction_code, 0);
        tick();
        rst_n = 1;
        expect_out("reboot", 0, 32'h0, 0);
        tick();
        expect_out("refetch", 1, 32'h0200_0000, 0);
        tick();
        tick();
        // Stalled grant: address must hold while req stays high.
        gnt_en = 0;
        inst_ready = 1;
        k = 0;
        @(negedge clk);
        while (!imem.req && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("stall_req_seen", imem.req, 1);
        check("stall_addr0", imem.addr, 32'h0200_0008);
        repeat (2) begin
            @(negedge clk);
            check("stall_req", imem.req, 1);
            check("stall_addr", imem.addr, 32'h0200_0008);
        end
        tick();
        gnt_en = 1;
        hold_rsp = 1;
        expect_out("stall_grant", 1, 32'h0200_0008, 0);
        tick();
        gnt_en = 0;
        redirect_valid = 1;
        redirect_pc = 32'h0200_09c6;
        expect_out("pc_advanced", 1, 32'h0200_000c, 0);
        tick();
        redirect_valid = 0;
        hold_rsp = 0;
        expect_out("drain_wait", 0, 32'h0, 0);
        tick();
        expect_out("drain_drop", 0, 32'h0, 0);
        tick();
        gnt_en = 1;
        expect_out("redirect_fetch", 1, 32'h0200_09c4, 0);
        tick();
        // Redirect coinciding with a grant and a response.
        redirect_valid = 1;
        redirect_pc = 32'h0200_1000;
        expect_out("coincide", 1, 32'h0200_09c8, 0);
        tick();
        redirect_valid = 0;
        expect_out("coincide_drain", 0, 32'h0, 0);
        tick();
        expect_out("coincide_fetch", 1, 32'h0200_1000, 0);
        tick();
        for (int i = 0; i < 300; i++) begin
            gnt_en = $urandom_range(0, 3) != 0;
            inst_ready = $urandom_range(0, 2) != 0;
            hold_rsp = $urandom_range(0, 3) == 0;
            redirect_valid = $urandom_range(0, 19) == 0;
            redirect_pc = $urandom;
            tick();
        end
        redirect_valid = 0;
        hold_rsp = 0;
        gnt_en = 0;
        inst_ready = 1;
        repeat (20) tick();
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);
        check("final_valid", inst_valid, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
